iter_muldiv: RTL

//   Multi-cycle unsigned multiply/divide unit for the execute stage. Consumes the
//   sum/cout of one shared cla32 instance every cycle: shift-add multiply, restoring divide.

---
 rtl/iter_muldiv_pkg.sv | 30 +++
 rtl/iter_muldiv_if.sv | 26 ++
 rtl/iter_muldiv_cla32.sv | 54 +++++
 rtl/iter_muldiv.sv | 128 ++++++++++++
 4 files changed

// File: rtl/iter_muldiv_pkg.sv
// Shared constants, op/state encodings and result selection for the iterative
// multiply/divide unit.
package iter_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // High product half and remainder both finish in hi; low half and quotient in lo.
    function automatic logic [XLEN-1:0] selectResult(
        input op_e             op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo
    );
        return (op == OP_MULHU || op == OP_REMU) ? hi : lo;
    endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response handshake bundle between the issue stage and the
// iterative multiply/divide unit.
interface iter_muldiv_if;
    import iter_muldiv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/iter_muldiv_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained through
// group generate/propagate terms.
module cla32
    import iter_muldiv_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            cin_i,
    output logic [XLEN-1:0] sum_o,
    output logic            cout_o
);

    localparam int NGRP = XLEN / 4;

    logic [XLEN-1:0] prop;
    logic [XLEN-1:0] gen;
    logic [XLEN-1:0] carry;
    logic [NGRP-1:0] grpGen;
    logic [NGRP-1:0] grpProp;
    logic [NGRP:0]   grpCarry;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    always_comb begin
        grpGen      = '0;
        grpProp     = '0;
        grpCarry    = '0;
        carry       = '0;
        grpCarry[0] = cin_i;
        for (int k = 0; k < NGRP; k++) begin
            grpGen[k]  = gen[4*k+3]
                       | (prop[4*k+3] & gen[4*k+2])
                       | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                       | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            grpProp[k] = &prop[4*k +: 4];
            // In-group carries all derive from the group carry-in, not from each other.
            carry[4*k]   = grpCarry[k];
            carry[4*k+1] = gen[4*k] | (prop[4*k] & grpCarry[k]);
            carry[4*k+2] = gen[4*k+1]
                         | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & grpCarry[k]);
            carry[4*k+3] = gen[4*k+2]
                         | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grpCarry[k]);
            grpCarry[k+1] = grpGen[k] | (grpProp[k] & grpCarry[k]);
        end
    end

    assign sum_o  = prop ^ carry;
    assign cout_o = grpCarry[NGRP];

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit: shift-add multiply and
// restoring divide, one step per cycle through a single shared cla32.
module iter_muldiv
    import iter_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    iter_muldiv_if.slave bus
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0]  addA, addB, addSum;
    logic             addCin, addCout;
    logic [XLEN-1:0]  remShift;
    logic             divOk;
    logic             isDiv;
    logic             reqDivZero;

    assign isDiv      = op_q[1];
    assign remShift   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign reqDivZero = bus.op[1] && (bus.b == '0);

    // Divide computes rs - b as rs + ~b + 1; multiply adds b only when the current lo bit is set.
    always_comb begin
        addA   = hi_q;
        addB   = '0;
        addCin = 1'b0;
        if (isDiv) begin
            addA   = remShift;
            addB   = ~b_q;
            addCin = 1'b1;
        end else if (lo_q[0]) begin
            addB = b_q;
        end
    end

    cla32 u_cla32 (
        .a_i    (addA),
        .b_i    (addB),
        .cin_i  (addCin),
        .sum_o  (addSum),
        .cout_o (addCout)
    );

    // The shifted-out msb covers remainders that momentarily need 33 bits.
    assign divOk = hi_q[XLEN-1] | addCout;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d  = op_e'(bus.op);
                    b_d   = bus.b;
                    hi_d  = '0;
                    lo_d  = bus.a;
                    cnt_d = '0;
                    if (reqDivZero) begin
                        state_d  = S_DONE;
                        result_d = (op_e'(bus.op) == OP_DIVU) ? '1 : bus.a;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (isDiv) begin
                    hi_d = divOk ? addSum : remShift;
                    lo_d = {lo_q[XLEN-2:0], divOk};
                end else begin
                    {hi_d, lo_d} = {addCout, addSum, lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = S_DONE;
                    result_d = selectResult(op_q, hi_d, lo_d);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;

endmodule
